// File: rtl/bp_fe_mem_responder.sv
// Single-outstanding memory endpoint behind the FE I-cache UCE.
// A command is latched on accept, waits out a fixed latency, then touches a
// 64-bit-word RAM one word per cycle before presenting one response.
// Handshake: mem_cmd is taken on the edge where mem_cmd_v_i & mem_cmd_ready_o;
// mem_resp is held stable while mem_resp_v_o is high and is consumed on the
// edge where mem_resp_yumi_i is high (yumi is ignored while valid is low).
// The config parameters below stand in for the fields a processor config
// would normally supply.
// Message layout, MSB to LSB: data, payload (lce_id, way_id), size, addr, msg_type.
module bp_fe_mem_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int mem_els_p         = 1024,
    parameter int latency_p         = 4,
    localparam int payload_width_lp = lce_id_width_p + $clog2(lce_assoc_p),
    localparam int hdr_width_lp     = payload_width_lp + 3 + paddr_width_p + 4,
    localparam int cce_mem_msg_width_lp = cce_block_width_p + hdr_width_lp
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,
    output logic [1:0]                      state_o
);

    localparam int idx_w    = $clog2(mem_els_p);
    localparam int cnt_w    = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int lat_load = (latency_p > 1) ? latency_p - 2 : 0;

    localparam logic [3:0] e_cce_mem_rd    = 4'd0;
    localparam logic [3:0] e_cce_mem_wr    = 4'd1;
    localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

    typedef struct packed {
        logic [payload_width_lp-1:0] payload;
        logic [2:0]                  size;
        logic [paddr_width_p-1:0]    addr;
        logic [3:0]                  msg_type;
    } hdr_s;

    typedef enum logic [1:0] {e_idle, e_latency, e_access, e_resp} state_e;

    state_e                       state_r, state_n;
    hdr_s                         hdr_r, cmd_hdr;
    logic [cce_block_width_p-1:0] data_r, resp_data_r;
    logic [cnt_w-1:0]             cnt_r;
    logic [2:0]                   k_r;
    logic [63:0]                  mem [mem_els_p];

    logic             accept, is_rd, is_wr, sub;
    logic [3:0]       nwords_r, nwords_cmd;
    logic [idx_w-1:0] word_idx, ram_addr;
    logic [2:0]       off;
    logic [7:0]       be_base, be;
    logic [63:0]      rdata, wsrc, wword, rshift, rword;

    // Words touched by a command: 2^size bytes, at least one word, at most a block.
    function automatic logic [3:0] calc_nwords(input logic [3:0] t, input logic [2:0] s);
        if (!(t == e_cce_mem_rd || t == e_cce_mem_wr || t == e_cce_mem_uc_rd || t == e_cce_mem_uc_wr))
            return 4'd0;
        else if (s <= 3'd3) return 4'd1;
        else if (s >= 3'd6) return 4'd8;
        else return 4'd1 << (s - 3'd3);
    endfunction

    assign cmd_hdr    = hdr_s'(mem_cmd_i[hdr_width_lp-1:0]);
    assign nwords_cmd = calc_nwords(cmd_hdr.msg_type, cmd_hdr.size);
    assign accept     = mem_cmd_v_i & mem_cmd_ready_o;

    assign mem_cmd_ready_o = reset_n_i & (state_r == e_idle);
    assign mem_resp_v_o    = (state_r == e_resp);
    assign mem_resp_o      = {resp_data_r, hdr_r};
    assign state_o         = state_r;

    // RAM address, read extraction and byte-merged write word for beat k.
    always_comb begin
        is_rd    = (hdr_r.msg_type == e_cce_mem_rd) || (hdr_r.msg_type == e_cce_mem_uc_rd);
        is_wr    = (hdr_r.msg_type == e_cce_mem_wr) || (hdr_r.msg_type == e_cce_mem_uc_wr);
        nwords_r = calc_nwords(hdr_r.msg_type, hdr_r.size);
        sub      = (hdr_r.size < 3'd3);
        off      = sub ? hdr_r.addr[2:0] : 3'd0;
        word_idx = hdr_r.addr[3 +: idx_w];
        // Blocks start at their aligned base; nwords is a power of two here.
        ram_addr = (word_idx & ~idx_w'(nwords_r - 4'd1)) + idx_w'(k_r);
        case (hdr_r.size)
            3'd0:    be_base = 8'h01;
            3'd1:    be_base = 8'h03;
            3'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be     = be_base << off;
        rdata  = mem[ram_addr];
        wsrc   = sub ? (data_r[63:0] << {off, 3'b000}) : data_r[{k_r, 6'b000000} +: 64];
        rshift = rdata >> {off, 3'b000};
        wword  = rdata;
        rword  = '0;
        for (int b = 0; b < 8; b++) begin
            if (be[b])      wword[8*b +: 8] = wsrc[8*b +: 8];
            if (be_base[b]) rword[8*b +: 8] = rshift[8*b +: 8];
        end
    end

    // Next-state logic for the command lifecycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle: begin
                if (accept) begin
                    if (latency_p > 1)          state_n = e_latency;
                    else if (nwords_cmd == 4'd0) state_n = e_resp;
                    else                         state_n = e_access;
                end
            end
            e_latency: begin
                if (cnt_r == '0) state_n = (nwords_r == 4'd0) ? e_resp : e_access;
            end
            e_access: begin
                if ({1'b0, k_r} == nwords_r - 4'd1) state_n = e_resp;
            end
            e_resp: begin
                if (mem_resp_yumi_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    // State register; reset discards any in-flight command.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_idle;
        else            state_r <= state_n;
    end

    // Command latch, latency/word counters and response data assembly.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_r       <= '0;
            data_r      <= '0;
            resp_data_r <= '0;
            cnt_r       <= '0;
            k_r         <= '0;
        end else if (accept) begin
            hdr_r       <= cmd_hdr;
            data_r      <= mem_cmd_i[cce_mem_msg_width_lp-1 -: cce_block_width_p];
            resp_data_r <= '0;
            cnt_r       <= cnt_w'(lat_load);
            k_r         <= '0;
        end else if (state_r == e_latency) begin
            if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
        end else if (state_r == e_access) begin
            k_r <= (state_n == e_resp) ? 3'd0 : k_r + 3'd1;
            if (is_rd) resp_data_r[{k_r, 6'b000000} +: 64] <= rword;
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (state_r == e_access && is_wr) mem[ram_addr] <= wword;
    end

endmodule

// File: tb/tb_bp_fe_mem_responder.sv
// Randomised scoreboard bench for bp_fe_mem_responder with a word-array memory model.
module tb_bp_fe_mem_responder;

    localparam int L   = 4;
    localparam int MW  = 512 + 7 + 3 + 40 + 4;
    localparam logic [3:0] RD = 4'd0, WR = 4'd1, UC_RD = 4'd2, UC_WR = 4'd3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [MW-1:0] cmd;
    logic          cmd_v;
    logic          ready;
    logic [MW-1:0] resp;
    logic          resp_v;
    logic          yumi;
    logic [1:0]    state;

    logic [MW-1:0] exp_q[$];
    int            lat_q[$];
    logic [63:0]   ref_mem [1024];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_c = 0;
    int            force_hold = 0;
    int            yumi_cyc = 0;

    bp_fe_mem_responder #(.latency_p(L)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v),
        .mem_cmd_ready_o(ready), .mem_resp_o(resp), .mem_resp_v_o(resp_v),
        .mem_resp_yumi_i(yumi), .state_o(state)
    );

    // Clock and free-running edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] pack(input logic [3:0] t, input logic [39:0] a,
                                            input logic [2:0] s, input logic [6:0] pl,
                                            input logic [511:0] d);
        return {d, pl, s, a, t};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int nwords(input logic [3:0] t, input logic [2:0] s);
        int bytes = 1 << s;
        if (t > UC_WR) return 0;
        if (bytes <= 8) return 1;
        return (bytes / 8 > 8) ? 8 : bytes / 8;
    endfunction

    // Reference: RAM as an array of words; only the first `limit` block words get written.
    task automatic model_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                             input logic [511:0] d, input int limit, output logic [511:0] r);
        int nw   = nwords(t, s);
        int idx  = int'(a[12:3]);
        int off  = int'(a[2:0]);
        int nb   = 1 << s;
        int base;
        r = '0;
        if (nw == 0) return;
        base = idx - (idx % nw);
        if (t == RD || t == UC_RD) begin
            if (s < 3) for (int b = 0; b < nb; b++) r[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
            else       for (int k = 0; k < nw; k++) r[64*k +: 64] = ref_mem[base+k];
        end else begin
            if (s < 3) for (int b = 0; b < nb; b++) ref_mem[idx][8*(off+b) +: 8] = d[8*b +: 8];
            else       for (int k = 0; k < nw && k < limit; k++) ref_mem[base+k] = d[64*k +: 64];
        end
    endtask

    // Driver: present a command, wait for accept, push the expected response.
    task automatic send(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                        input logic [511:0] d, input int limit, input bit expect_resp);
        logic [6:0]   pl = 7'($urandom);
        logic [511:0] r;
        int           n = 0;
        @(negedge clk);
        cmd   = pack(t, a, s, pl, d);
        cmd_v = 1'b1;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready stuck at 0, want 1");
            cmd_v = 1'b0;
            return;
        end
        model_cmd(t, a, s, d, limit, r);
        if (expect_resp) begin
            exp_q.push_back(pack(t, a, s, pl, r));
            lat_q.push_back(cyc + L + nwords(t, s));
        end
        last_c = cyc;
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
        cmd   = {rand512(), 54'($urandom), 32'($urandom)} & {MW{1'b1}};
    endtask

    // Monitor: pop and compare on each new response, check stability, drive yumi.
    initial begin
        logic [MW-1:0] held;
        logic [MW-1:0] e;
        bit            in_resp = 0;
        int            hold = 0;
        int            lat;
        yumi = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || !resp_v) begin
                in_resp = 0;
                yumi    = 1'($urandom_range(0, 1));
            end else begin
                if (!in_resp) begin
                    in_resp = 1;
                    held    = resp;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got %h, want none", resp);
                    end else begin
                        e   = exp_q.pop_front();
                        lat = lat_q.pop_front();
                        check("resp_msg", resp, e);
                        check("resp_latency", MW'(cyc), MW'(lat));
                    end
                    hold       = (force_hold > 0) ? force_hold : $urandom_range(0, 2);
                    force_hold = 0;
                end else begin
                    check("resp_stable", resp, held);
                end
                check("ready_in_resp", MW'(ready), MW'(0));
                if (hold > 0) begin
                    hold--;
                    yumi = 1'b0;
                end else begin
                    yumi     = 1'b1;
                    yumi_cyc = cyc;
                end
            end
        end
    end

    // Main sequence: reset, preload, directed cases, random traffic, drain.
    initial begin
        logic [511:0] d;
        logic [39:0]  a;
        logic [2:0]   s;
        logic [3:0]   t;
        int           n;
        reset_n = 1'b0;
        cmd     = pack(4'd4, 40'h40, 3'd3, 7'h11, '0);
        cmd_v   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", MW'(ready), MW'(0));
            check("rst_resp_v", MW'(resp_v), MW'(0));
            if (i == 0) check("rst_resp", resp, '0);
        end
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", MW'(ready), MW'(1));
        exp_q.push_back(pack(4'd4, 40'h40, 3'd3, 7'h11, '0));
        lat_q.push_back(cyc + L);
        @(posedge clk);
        #1;
        cmd_v = 1'b0;

        for (int i = 0; i < 128; i++) send(WR, 40'(i * 64), 3'd6, rand512(), 8, 1);

        send(UC_WR, 40'h80, 3'd3, 512'h1122334455667788, 8, 1);
        send(UC_RD, 40'h80, 3'd3, '0, 8, 1);

        for (int k = 0; k < 8; k++) d[64*k +: 64] = 64'hA000 + 64'(k);
        send(WR, 40'h1000, 3'd6, d, 8, 1);
        send(RD, 40'h1010, 3'd6, '0, 8, 1);

        send(UC_WR, 40'h200, 3'd3, {448'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 8, 1);
        send(UC_WR, 40'h203, 3'd0, 512'h5A, 8, 1);
        send(UC_RD, 40'h200, 3'd3, '0, 8, 1);
        send(UC_RD, 40'h203, 3'd0, '0, 8, 1);

        force_hold = 10;
        send(UC_RD, 40'h80, 3'd3, '0, 8, 1);
        send(UC_RD, 40'h200, 3'd3, '0, 8, 1);
        check("bp_accept_cycle", MW'(last_c), MW'(yumi_cyc + 1));

        // Reset during the fourth beat of a block write: three beats have landed.
        send(WR, 40'h1800, 3'd6, rand512(), 3, 0);
        n = 0;
        while (cyc != last_c + 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_ready", MW'(ready), MW'(0));
        check("midrst_resp_v", MW'(resp_v), MW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst_ready_back", MW'(ready), MW'(1));
        repeat (20) @(negedge clk);
        send(RD, 40'h1800, 3'd6, '0, 8, 1);

        for (int i = 0; i < 120; i++) begin
            t = 4'($urandom_range(0, 5));
            s = 3'($urandom_range(0, 7));
            a = 40'($urandom_range(0, 'h3FFF));
            if (s < 3) a = a & ~40'((1 << s) - 1);
            send(t, a, s, rand512(), 8, 1);
        end

        n = 0;
        while ((exp_q.size() != 0 || resp_v) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", MW'(exp_q.size()), MW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
